// File: rtl/johnson_phase_decoder_pkg.sv
// rtl/johnson_phase_decoder_pkg.sv - shared Johnson code helpers, default width and FSM states
package johnson_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int PHASES    = 2 * WIDTH_DEF;

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } fsm_e;

    // Legal iff the ring has at most one 0/1 boundary inside the low w bits.
    function automatic logic johnson_legal(input logic [31:0] q, input int w);
        int edges;
        edges = 0;
        for (int i = 0; i < w - 1; i++) begin
            if (q[i] != q[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

    function automatic int johnson_idx(input logic [31:0] q, input int w);
        int ones;
        ones = 0;
        for (int i = 0; i < w; i++) begin
            ones += int'(q[i]);
        end
        return q[w-1] ? (2 * w - ones) : ones;
    endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// rtl/johnson_phase_decoder_if.sv - Johnson code input and decoded status bundle
interface johnson_phase_decoder_if #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8,
    parameter int REVW  = 16
);
    localparam int N_PHASE = 2 * WIDTH;
    localparam int IDXW    = $clog2(N_PHASE);

    logic [WIDTH-1:0]   q;
    logic [N_PHASE-1:0] phase;
    logic [IDXW-1:0]    phase_idx;
    logic               valid;
    logic               illegal;
    logic               seq_err;
    logic               wrap;
    logic               locked;
    logic               err_sticky;
    logic [ERRW-1:0]    err_count;
    logic [REVW-1:0]    rev_count;

    modport master (
        output q,
        input  phase, phase_idx, valid, illegal, seq_err, wrap,
               locked, err_sticky, err_count, rev_count
    );

    modport slave (
        input  q,
        output phase, phase_idx, valid, illegal, seq_err, wrap,
               locked, err_sticky, err_count, rev_count
    );
endinterface

// File: rtl/johnson_phase_decoder_code_check.sv
// rtl/johnson_phase_decoder_code_check.sv - combinational Johnson code legality and index
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] i_q,
    output logic             o_legal,
    output logic [IDXW-1:0]  o_idx
);

    logic [31:0] w_q32;

    assign w_q32   = 32'(i_q);
    assign o_legal = johnson_legal(w_q32, WIDTH);
    assign o_idx   = o_legal ? IDXW'(johnson_idx(w_q32, WIDTH)) : '0;

endmodule

// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - registered phase decode, successor check, lock FSM and counters
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOCK_CNT = 4,
    parameter int ERRW     = 8,
    parameter int REVW     = 16
) (
    input  logic clk,
    input  logic reset,
    johnson_phase_decoder_if.slave bus
);

    localparam int N_PHASE = 2 * WIDTH;
    localparam int IDXW    = $clog2(N_PHASE);

    localparam logic [0:0] ST_ACQUIRE = ACQUIRE;
    localparam logic [0:0] ST_LOCKED  = LOCKED;

    logic                w_legal;
    logic [IDXW-1:0]     w_idx;
    logic [IDXW-1:0]     w_succ_idx;
    logic                w_prev_last;
    logic                w_checked;
    logic                w_correct;
    logic                w_seq_err;
    logic                w_illegal;
    logic                w_err;
    logic                w_wrap;

    logic [0:0]          r_state;
    logic [3:0]          r_succ_cnt;
    logic                r_prev_ok;
    logic [IDXW-1:0]     r_prev_idx;
    logic [N_PHASE-1:0]  r_phase;
    logic [IDXW-1:0]     r_phase_idx;
    logic                r_valid;
    logic                r_illegal;
    logic                r_seq_err;
    logic                r_wrap;
    logic                r_err_sticky;
    logic [ERRW-1:0]     r_err_count;
    logic [REVW-1:0]     r_rev_count;

    johnson_code_check #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_code_check (
        .i_q     (bus.q),
        .o_legal (w_legal),
        .o_idx   (w_idx)
    );

    assign w_prev_last = (r_prev_idx == IDXW'(N_PHASE - 1));
    assign w_succ_idx  = w_prev_last ? '0 : r_prev_idx + 1'b1;
    assign w_checked   = r_prev_ok && w_legal;
    assign w_correct   = w_checked && (w_idx == w_succ_idx);
    assign w_seq_err   = w_checked && !w_correct;
    assign w_illegal   = !w_legal;
    assign w_err       = w_illegal || w_seq_err;
    assign w_wrap      = w_correct && w_prev_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= '0;
            r_phase_idx <= '0;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
            r_seq_err   <= 1'b0;
            r_wrap      <= 1'b0;
            r_prev_ok   <= 1'b0;
            r_prev_idx  <= '0;
        end else begin
            r_phase     <= w_legal ? (N_PHASE'(1) << w_idx) : '0;
            r_phase_idx <= w_idx;
            r_valid     <= w_legal;
            r_illegal   <= w_illegal;
            r_seq_err   <= w_seq_err;
            r_wrap      <= w_wrap;
            r_prev_ok   <= w_legal;
            if (w_legal) r_prev_idx <= w_idx;
        end
    end

    // The LOCK_CNT-th correct successor moves to LOCKED; any error drops back.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ACQUIRE;
            r_succ_cnt <= '0;
        end else begin
            case (r_state)
                ST_ACQUIRE: begin
                    if (w_err) begin
                        r_succ_cnt <= '0;
                    end else if (w_correct) begin
                        if (r_succ_cnt == 4'(LOCK_CNT - 1)) begin
                            r_state    <= ST_LOCKED;
                            r_succ_cnt <= '0;
                        end else begin
                            r_succ_cnt <= r_succ_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_err) begin
                        r_state    <= ST_ACQUIRE;
                        r_succ_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            r_rev_count  <= '0;
        end else begin
            if (w_err) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            end
            if (w_wrap && (r_state == ST_LOCKED)) r_rev_count <= r_rev_count + 1'b1;
        end
    end

    assign bus.phase      = r_phase;
    assign bus.phase_idx  = r_phase_idx;
    assign bus.valid      = r_valid;
    assign bus.illegal    = r_illegal;
    assign bus.seq_err    = r_seq_err;
    assign bus.wrap       = r_wrap;
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;
    assign bus.rev_count  = r_rev_count;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - directed and randomized checks against a phase-table reference model
module tb_johnson_phase_decoder;

    localparam int W    = 4;
    localparam int NPH  = 2 * W;
    localparam int LOCK = 4;

    logic clk;
    logic reset;

    johnson_phase_decoder_if #(.WIDTH(W), .ERRW(8), .REVW(16)) jif ();

    johnson_phase_decoder #(
        .WIDTH    (W),
        .LOCK_CNT (LOCK),
        .ERRW     (8),
        .REVW     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (jif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] code_tab [NPH];

    int m_prev_ok, m_prev_idx, m_locked, m_succ;
    int m_err_cnt, m_rev, m_sticky;
    int e_phase, e_idx, e_valid, e_illegal, e_seq, e_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] code, input logic rst);
        int idx, correct, err;
        idx = -1;
        for (int k = 0; k < NPH; k++) if (code_tab[k] == code) idx = k;
        if (rst) begin
            m_prev_ok = 0; m_prev_idx = 0; m_locked = 0; m_succ = 0;
            m_err_cnt = 0; m_rev = 0; m_sticky = 0;
            e_phase = 0; e_idx = 0; e_valid = 0; e_illegal = 0; e_seq = 0; e_wrap = 0;
            return;
        end
        correct   = 0;
        e_seq     = 0;
        e_wrap    = 0;
        e_illegal = (idx < 0);
        if (idx >= 0 && m_prev_ok != 0) begin
            if (idx == (m_prev_idx + 1) % NPH) correct = 1;
            else e_seq = 1;
            e_wrap = correct && (m_prev_idx == NPH - 1);
        end
        err = e_illegal || e_seq;
        if (e_wrap && m_locked != 0) m_rev = (m_rev + 1) % 65536;
        if (err) begin
            m_sticky = 1;
            if (m_err_cnt < 255) m_err_cnt++;
        end
        if (m_locked != 0) begin
            if (err) begin m_locked = 0; m_succ = 0; end
        end else if (err) begin
            m_succ = 0;
        end else if (correct) begin
            m_succ++;
            if (m_succ == LOCK) begin m_locked = 1; m_succ = 0; end
        end
        m_prev_ok = (idx >= 0);
        if (idx >= 0) m_prev_idx = idx;
        e_valid = (idx >= 0);
        e_idx   = (idx >= 0) ? idx : 0;
        e_phase = (idx >= 0) ? (1 << idx) : 0;
    endtask

    task automatic step(input logic [3:0] code, input logic rst);
        @(negedge clk);
        jif.q = code;
        reset = rst;
        @(posedge clk);
        #1;
        model(code, rst);
        chk("phase",      32'(jif.phase),      32'(e_phase));
        chk("phase_idx",  32'(jif.phase_idx),  32'(e_idx));
        chk("valid",      32'(jif.valid),      32'(e_valid));
        chk("illegal",    32'(jif.illegal),    32'(e_illegal));
        chk("seq_err",    32'(jif.seq_err),    32'(e_seq));
        chk("wrap",       32'(jif.wrap),       32'(e_wrap));
        chk("locked",     32'(jif.locked),     32'(m_locked));
        chk("err_sticky", 32'(jif.err_sticky), 32'(m_sticky));
        chk("err_count",  32'(jif.err_count),  32'(m_err_cnt));
        chk("rev_count",  32'(jif.rev_count),  32'(m_rev));
    endtask

    initial begin
        int r, nxt;
        logic [3:0] c;
        for (int k = 0; k < NPH; k++) begin
            int v;
            v = (k <= W) ? ((1 << k) - 1) : ((32'hF << (k - W)) & 32'hF);
            code_tab[k] = 4'(v);
        end
        jif.q = 4'b0000;
        reset = 1'b1;

        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // full revolution, lock on sample 5, one wrap
        step(4'b0000, 1'b0); step(4'b0001, 1'b0); step(4'b0011, 1'b0);
        step(4'b0111, 1'b0); step(4'b1111, 1'b0);
        chk("lock_after_4", 32'(jif.locked), 32'd1);
        step(4'b1110, 1'b0); step(4'b1100, 1'b0); step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        chk("first_rev", 32'(jif.rev_count), 32'd1);

        // illegal while locked, then resume unchecked and re-lock
        step(4'b0101, 1'b0);
        step(4'b0011, 1'b0); step(4'b0111, 1'b0); step(4'b1111, 1'b0);
        step(4'b1110, 1'b0); step(4'b1100, 1'b0);
        step(4'b1000, 1'b0); step(4'b0000, 1'b0); step(4'b0001, 1'b0);

        // skip while locked
        step(4'b0111, 1'b0);
        chk("skip_idx", 32'(jif.phase_idx), 32'd3);

        // held code
        step(4'b1111, 1'b0); step(4'b1110, 1'b0); step(4'b1100, 1'b0);
        step(4'b1000, 1'b0); step(4'b0000, 1'b0); step(4'b0001, 1'b0);
        step(4'b0011, 1'b0); step(4'b0011, 1'b0);

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            step(4'b0101, 1'b0);
            step(4'b0000, 1'b0);
        end
        chk("err_sat", 32'(jif.err_count), 32'd255);

        // re-lock, then reset together with an illegal code
        for (int k = 1; k <= 6; k++) step(code_tab[k % NPH], 1'b0);
        step(4'b0101, 1'b1);
        chk("rst_sticky", 32'(jif.err_sticky), 32'd0);

        // randomized walk with injected faults
        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 99);
            nxt = (m_prev_ok != 0) ? (m_prev_idx + 1) % NPH : $urandom_range(0, NPH - 1);
            if (r < 80)      c = code_tab[nxt];
            else if (r < 87) c = code_tab[m_prev_idx];
            else if (r < 93) c = 4'($urandom_range(0, 15));
            else if (r < 97) c = code_tab[(nxt + 1) % NPH];
            else             c = 4'($urandom_range(0, 15));
            step(c, (r >= 97) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
